// File: rtl/ifu_pkg.sv
// Shared types for the instruction fetch/issue front end: FSM states,
// next-PC select codes and opcode field constants.
package ifu_pkg;

  localparam int                    OPCODE_W   = 6;
  localparam logic [OPCODE_W-1:0]   OPCODE_NOP = 6'b000000;

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT_MEM,
    S_ISSUE,
    S_WAIT_IN,
    S_HALT
  } ifu_state_t;

  typedef enum logic [1:0] {
    NPC_SEQ,
    NPC_TARGET,
    NPC_RESET,
    NPC_HOLD
  } npc_sel_t;

endpackage

// File: rtl/ifu_next_pc.sv
// Combinational next-PC / next-state choice applied when the decoder accepts
// an issued instruction, in decoder-sideband priority order.
module ifu_next_pc
  import ifu_pkg::*;
#(
  parameter int                ADDR_W     = 10,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              reset_pc_i,
  input  logic              halt_pc_i,
  input  logic              jump_take_i,
  input  logic              br_eq_i,
  input  logic              br_above_i,
  input  logic              flag_eq_i,
  input  logic              flag_above_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  input  logic              in_wait_i,
  output logic [ADDR_W-1:0] npc_o,
  output ifu_state_t        state_o
);

  npc_sel_t sel;

  always_comb begin
    sel     = NPC_SEQ;
    state_o = S_FETCH;
    if (reset_pc_i) begin
      sel = NPC_RESET;
    end else if (halt_pc_i) begin
      sel     = NPC_HOLD;
      state_o = S_HALT;
    end else if (jump_take_i || (br_eq_i && flag_eq_i) || (br_above_i && flag_above_i)) begin
      sel = NPC_TARGET;
    end else if (in_wait_i) begin
      // pc advances later, when the external input is acknowledged
      sel     = NPC_HOLD;
      state_o = S_WAIT_IN;
    end
  end

  always_comb begin
    unique case (sel)
      NPC_RESET:  npc_o = RESET_ADDR;
      NPC_HOLD:   npc_o = pc_i;
      NPC_TARGET: npc_o = jump_target_i;
      default:    npc_o = pc_i + ADDR_W'(1);
    endcase
  end

endmodule

// File: rtl/instr_fetch_issue.sv
// Instruction fetch/issue front end: owns the PC, fetches one word per instruction
// and hands it to the decoder. Define IFU_RETIRE_CNT_EN to add the retire_cnt output.
module instr_fetch_issue
  import ifu_pkg::*;
#(
  parameter int                ADDR_W     = 10,
  parameter int                INSTR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_valid,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic [INSTR_W-1:0]  instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic                instr_valid,
  input  logic                instr_ready,
  input  logic                reset_pc,
  input  logic                halt_pc,
  input  logic                jump_take,
  input  logic                br_eq,
  input  logic                br_above,
  input  logic                flag_eq,
  input  logic                flag_above,
  input  logic [ADDR_W-1:0]   jump_target,
  input  logic                in_wait,
  input  logic                in_ack,
  output logic [ADDR_W-1:0]   pc,
`ifdef IFU_RETIRE_CNT_EN
  output logic [31:0]         retire_cnt,
`endif
  output logic                halted
);

  ifu_state_t         state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic               req_q;
  logic               instr_valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic               halted_q;
  logic [1:0]         stale_q;
  logic [1:0]         stale_d;
  logic               inflight;
  logic [2:0]         owed;
  logic [ADDR_W-1:0]  nxt_pc;
  ifu_state_t         nxt_state;

  ifu_next_pc #(
    .ADDR_W     (ADDR_W),
    .RESET_ADDR (RESET_ADDR)
  ) u_next_pc (
    .pc_i          (pc_q),
    .reset_pc_i    (reset_pc),
    .halt_pc_i     (halt_pc),
    .jump_take_i   (jump_take),
    .br_eq_i       (br_eq),
    .br_above_i    (br_above),
    .flag_eq_i     (flag_eq),
    .flag_above_i  (flag_above),
    .jump_target_i (jump_target),
    .in_wait_i     (in_wait),
    .npc_o         (nxt_pc),
    .state_o       (nxt_state)
  );

  // Responses still owed by memory when reset hits are counted and dropped later.
  assign inflight = (state_q == S_WAIT_MEM) || ((state_q == S_FETCH) && req_q);

  always_comb begin
    owed = {1'b0, stale_q} + {2'b00, inflight};
    if (imem_valid && (owed != 3'd0)) owed = owed - 3'd1;
    stale_d = (owed > 3'd3) ? 2'd3 : owed[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_ADDR;
      req_q         <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      halted_q      <= 1'b0;
      stale_q       <= stale_d;
    end else begin
      if (imem_valid && (stale_q != 2'd0)) stale_q <= stale_q - 2'd1;
      unique case (state_q)
        S_FETCH: begin
          // Right after reset the strobe is still low; raise it for one cycle here.
          req_q <= ~req_q;
          if (req_q) state_q <= S_WAIT_MEM;
        end
        S_WAIT_MEM: begin
          if (imem_valid && (stale_q == 2'd0)) begin
            instr_q       <= imem_rdata;
            instr_valid_q <= 1'b1;
            state_q       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (instr_ready) begin
            instr_valid_q <= 1'b0;
            pc_q          <= nxt_pc;
            state_q       <= nxt_state;
            req_q         <= (nxt_state == S_FETCH);
            halted_q      <= (nxt_state == S_HALT);
          end
        end
        S_WAIT_IN: begin
          if (in_ack) begin
            pc_q    <= pc_q + ADDR_W'(1);
            req_q   <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_HALT: begin
          if (reset_pc) begin
            pc_q     <= RESET_ADDR;
            halted_q <= 1'b0;
            req_q    <= 1'b1;
            state_q  <= S_FETCH;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

`ifdef IFU_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt_q <= '0;
    end else if ((state_q == S_ISSUE) && instr_ready) begin
      retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[INSTR_W-1 -: OPCODE_W];
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign halted      = halted_q;

endmodule
